// File: rtl/dm_arb.sv
// Two-master data-memory arbiter. The CPU and DMA ports share one dm port, and only one
// access is in flight at a time: IDLE -> [WAIT] -> XFER -> DONE.
module dm_arb #(
  parameter int unsigned WAIT = 0,
  parameter bit          RR   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  // CPU port
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_ax,
  input  logic [31:0] c_x,
  input  logic [2:0]  c_op,
  input  logic [31:0] c_pcw,
  output logic        c_ack,
  output logic [31:0] c_z,
  output logic        c_stall,
  // DMA port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_ax,
  input  logic [31:0] d_x,
  input  logic [2:0]  d_op,
  output logic        d_ack,
  output logic [31:0] d_z,
  // data memory side
  output logic [31:0] m_ax,
  output logic [31:0] m_x,
  output logic [2:0]  m_op,
  output logic [31:0] m_pcw,
  output logic        m_en,
  input  logic [31:0] m_z,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StWait, StXfer, StDone} state_e;

  localparam int unsigned WaitM1 = (WAIT > 0) ? WAIT - 1 : 0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        win_q, win_d;   // 1 = DMA owns the current access
  logic        lp_q, lp_d;     // 1 = DMA was granted last
  logic        latch;
  logic        pick_dma;

  logic        we_q;
  logic [31:0] ax_q, x_q, pcw_q;
  logic [2:0]  op_q;
  logic        c_ack_q, d_ack_q;
  logic [31:0] c_z_q, d_z_q;

  // Sole requester wins; on conflict RR favours the port not granted last.
  assign pick_dma = d_req & (~c_req | (RR & ~lp_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    lp_d    = lp_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (c_req | d_req) begin
          latch = 1'b1;
          win_d = pick_dma;
          lp_d  = pick_dma;
          if (WAIT > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WaitM1);
          end else begin
            state_d = StXfer;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StXfer;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StXfer: state_d = StDone;
      StDone: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      win_q   <= 1'b0;
      lp_q    <= 1'b1;
      we_q    <= 1'b0;
      ax_q    <= '0;
      x_q     <= '0;
      op_q    <= '0;
      pcw_q   <= '0;
      c_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      c_z_q   <= '0;
      d_z_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      lp_q    <= lp_d;
      if (latch) begin
        we_q  <= pick_dma ? d_we : c_we;
        ax_q  <= pick_dma ? d_ax : c_ax;
        x_q   <= pick_dma ? d_x  : c_x;
        op_q  <= pick_dma ? d_op : c_op;
        pcw_q <= pick_dma ? 32'd0 : c_pcw;
      end
      c_ack_q <= (state_q == StXfer) & ~win_q;
      d_ack_q <= (state_q == StXfer) & win_q;
      if (state_q == StXfer) begin
        if (win_q) begin
          d_z_q <= m_z;
        end else begin
          c_z_q <= m_z;
        end
      end
    end
  end

  assign m_ax    = ax_q;
  assign m_x     = x_q;
  assign m_op    = op_q;
  assign m_pcw   = pcw_q;
  assign m_en    = (state_q == StXfer) & we_q;
  assign busy    = (state_q != StIdle);
  assign c_ack   = c_ack_q;
  assign d_ack   = d_ack_q;
  assign c_z     = c_z_q;
  assign d_z     = d_z_q;
  assign c_stall = c_req & ~c_ack_q;

endmodule
